// File: rtl/des_pkg.sv
// DES tables, bit permutations and key-rotation schedules shared by the
// iterative decryptor and the pipelined encryptor. Bit 63 is DES bit 1.
package des_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } dec_state_t;

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Encrypt: left-rotate before round i. Decrypt: right-rotate before round i.
    localparam int unsigned LSH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int unsigned RSH [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each box: 64 nibbles, row-major (row = {b5,b0}, col = b4..b1), entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] y;
        y = '0;
        for (int unsigned k = 0; k < 56; k++) y[6'(55 - k)] = key[6'(64 - PC1_T[k])];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int unsigned k = 0; k < 48; k++) y[6'(47 - k)] = cd[6'(56 - PC2_T[k])];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] r);
        logic [47:0] y;
        y = '0;
        for (int unsigned k = 0; k < 48; k++) y[6'(47 - k)] = r[5'(32 - E_T[k])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned k = 0; k < 32; k++) y[5'(31 - k)] = x[5'(32 - P_T[k])];
        return y;
    endfunction

    function automatic logic [31:0] s_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        logic [5:0]  idx;
        y = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            six = x[6'(47 - 6 * i) -: 6];
            idx = {six[5], six[0], six[4:1]};
            y[5'(31 - 4 * i) -: 4] = SBOX[3'(i)][8'(255 - 4 * idx) -: 4];
        end
        return y;
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd0:    return v;
            2'd1:    return {v[0], v[27:1]};
            default: return {v[1:0], v[27:2]};
        endcase
    endfunction

    function automatic logic [1:0] rsh_at(input logic [4:0] rnd);
        return (rnd < 5'd16) ? 2'(RSH[rnd[3:0]]) : 2'd0;
    endfunction

endpackage

// File: rtl/des_round.sv
// One DES decrypt round: rotate C,D right, derive the subkey, apply the Feistel step.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic [1:0]  rot,
    output logic [31:0] l_nxt,
    output logic [31:0] r_nxt,
    output logic [27:0] c_nxt,
    output logic [27:0] d_nxt
);

    logic [47:0] k;

    // The rotation precedes subkey selection so round 1 sees the unrotated C0,D0.
    always_comb begin
        c_nxt = ror28(c, rot);
        d_nxt = ror28(d, rot);
        k     = pc2({c_nxt, d_nxt});
        l_nxt = r;
        r_nxt = l ^ p_perm(s_sub(e_exp(r) ^ k));
    end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: UNROLL chained rounds per clock, 16/UNROLL clocks per block.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("des_decrypt_iter: UNROLL must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned LAST = 16 - UNROLL;

    dec_state_t  state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic        last_grp;

    logic [31:0] l_ch [UNROLL+1];
    logic [31:0] r_ch [UNROLL+1];
    logic [27:0] c_ch [UNROLL+1];
    logic [27:0] d_ch [UNROLL+1];

    assign l_ch[0]  = l_q;
    assign r_ch[0]  = r_q;
    assign c_ch[0]  = c_q;
    assign d_ch[0]  = d_q;
    assign last_grp = (cnt == 5'(LAST));

    for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
        des_round u_round (
            .l     (l_ch[g]),
            .r     (r_ch[g]),
            .c     (c_ch[g]),
            .d     (d_ch[g]),
            .rot   (rsh_at(cnt + 5'(g))),
            .l_nxt (l_ch[g+1]),
            .r_nxt (r_ch[g+1]),
            .c_nxt (c_ch[g+1]),
            .d_nxt (d_ch[g+1])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last_grp) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Block load, round iteration and result capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ip(in_data);
                        {c_q, d_q} <= pc1(in_key);
                        cnt        <= '0;
                    end
                end
                S_RUN: begin
                    l_q <= l_ch[UNROLL];
                    r_q <= r_ch[UNROLL];
                    c_q <= c_ch[UNROLL];
                    d_q <= d_ch[UNROLL];
                    cnt <= cnt + 5'(UNROLL);
                    if (last_grp) out_data <= fp({r_ch[UNROLL], l_ch[UNROLL]});
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter against a behavioural DES model.
module tb_des_decrypt_iter;

    localparam int unsigned UNROLL    = 1;
    localparam int          ROUND_CYC = 16 / UNROLL;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2 = 64'h8787878787878787;
    localparam logic [63:0] CT2 = 64'h0000000000000000;

    localparam int T_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int T_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int T_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int T_LSH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] in_key = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    des_decrypt_iter #(.UNROLL(UNROLL)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generic MSB-first selection: result holds n_out bits picked from an n_in-bit source.
    function automatic logic [63:0] perm(input logic [63:0] x, input int n_in, input int n_out, input int sel);
        logic [63:0] y;
        int          src;
        y = '0;
        for (int k = 0; k < n_out; k++) begin
            case (sel)
                0:       src = T_IP[k];
                1:       src = T_E[k];
                2:       src = T_P[k];
                3:       src = T_PC1[k];
                default: src = T_PC2[k];
            endcase
            y = (y << 1) | ((x >> (n_in - src)) & 64'd1);
        end
        return y;
    endfunction

    // Final permutation obtained by undoing the initial permutation.
    function automatic logic [63:0] inv_ip(input logic [63:0] y);
        logic [63:0] x;
        x = '0;
        for (int k = 0; k < 64; k++)
            if (((y >> (63 - k)) & 64'd1) != 64'd0) x = x | (64'd1 << (64 - T_IP[k]));
        return x;
    endfunction

    function automatic logic [31:0] sbox(input logic [47:0] x);
        logic [31:0] y;
        int six, row, col, v;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            six = int'(x >> (42 - 6 * i)) & 63;
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            v   = int'(SB[i] >> (252 - 4 * (row * 16 + col))) & 15;
            y   = (y << 4) | 32'(v);
        end
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] e;
        e = perm({32'd0, r}, 32, 48, 1);
        return 32'(perm({32'd0, sbox(48'(e) ^ k)}, 32, 32, 2));
    endfunction

    // Textbook DES: forward subkey list, consumed in reverse for decryption.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] din, input bit dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] lr;
        logic [31:0] l, r, t;
        cd = 56'(perm(key, 64, 56, 3));
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < T_LSH[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = 48'(perm({8'd0, c, d}, 56, 48, 4));
        end
        lr = perm(din, 64, 64, 0);
        l  = lr[63:32];
        r  = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ feistel(r, dec ? ks[15 - i] : ks[i]);
            l = t;
        end
        return inv_ip({r, l});
    endfunction

    // One block with latency measurement and optional output backpressure.
    task automatic do_block(input logic [63:0] key, input logic [63:0] ct, input logic [63:0] exp, input int bp);
        int n;
        bit ready_seen;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = ct;
        in_key    = key;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_key   = {$urandom, $urandom};
        in_data  = {$urandom, $urandom};
        n = 0;
        ready_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid || n > 200) break;
            ready_seen |= in_ready;
            n++;
        end
        check("latency", 64'(n), 64'(ROUND_CYC));
        check("in_ready_run", 64'(ready_seen), 64'd0);
        check("data", out_data, exp);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", out_data, exp);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Streamed blocks through the valid/ready ports with a scoreboard of expected plaintext.
    task automatic stream(input int nblk, input bit rnd, input bit gapchk);
        logic [63:0] kq[$], cq[$], eq[$];
        logic [63:0] key, pt;
        int got, cyc, last;
        bit acc;
        got = 0; cyc = 0; last = -1; acc = 1'b0;
        for (int i = 0; i < nblk; i++) begin
            if (rnd) begin
                key = {$urandom, $urandom};
                pt  = {$urandom, $urandom};
            end else begin
                key = (i % 2 == 0) ? K1 : K2;
                pt  = (i % 2 == 0) ? PT1 : PT2;
            end
            kq.push_back(key);
            cq.push_back(des_ref(key, pt, 1'b0));
            eq.push_back(pt);
        end
        while (got < nblk && cyc < nblk * 40 + 100) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                void'(kq.pop_front());
                void'(cq.pop_front());
                in_valid = 1'b0;
            end
            if (!in_valid) begin
                if (kq.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    in_key   = kq[0];
                    in_data  = cq[0];
                end else begin
                    in_key  = {$urandom, $urandom};
                    in_data = {$urandom, $urandom};
                end
            end
            acc = in_valid && in_ready;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    check("extra_out", 64'd1, 64'd0);
                end else begin
                    check(rnd ? "loop_data" : "b2b_data", out_data, eq[0]);
                    void'(eq.pop_front());
                end
                if (gapchk && last >= 0) check("b2b_gap", 64'(cyc - last), 64'(ROUND_CYC + 2));
                last = cyc;
                got++;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check(rnd ? "loop_count" : "b2b_count", 64'(got), 64'(nblk));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        do_block(K1, CT1, PT1, 0);
        do_block(K2, CT2, PT2, 0);
        do_block(K2 ^ 64'h0101010101010101, CT2, PT2, 0);
        do_block(K1, CT1, PT1, 10);

        stream(2, 1'b0, 1'b1);

        // Reset while block 1 is in round 7; nothing of it may emerge afterwards.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = CT1;
        in_key   = K1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        rstn = 1'b1;
        do_block(K2, CT2, PT2, 0);

        stream(1000, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
